cpu_trace_buffer: RTL and testbench
===================================

// Module: cpu_trace_buffer
// PURPOSE
//  Passive observer on the CPU debug outputs (CurrentState, PC, MSP, RSP, ValA, ValB).
//  Captures one trace record per control-FSM state change, or every cycle, into an on-chip FIFO.
//  Drains records through a valid/ready read port to a host or debug UART.
//  Consumer end of the CPU debug-output interface; sits beside stage7FullIntegration.
// PARAMETERS
//  DEPTH         16  FIFO entries; power of 2, >=2
//  CAPTURE_ALL   0   1: record every CAPTURE cycle; 0: record only when CurrentState != PrevState
//  STOP_ON_FULL  0   1: CAPTURE->DONE when FIFO becomes full; 0: keep running, drop and count
// PORTS
//  CLK          in   1   system clock, all logic on posedge
//  CtrlRst_n    in   1   synchronous, active-low reset
//  CurrentState in   5   CPU control-FSM state
//  PCIn         in   16  CPU PC
//  MSPIn        in   16  CPU main stack pointer
//  RSPIn        in   16  CPU return stack pointer
//  ValAIn       in   16  CPU ValA
//  ValBIn       in   16  CPU ValB
//  Arm          in   1   start capture; clears Overflow and DropCount
//  Disarm       in   1   abort to IDLE; FIFO contents kept
//  TrigPC       in   16  PC trigger value; ignored unless macro enabled
//  RdData       out  85  {State[84:80],PC,MSP,RSP,ValA,ValB}, head of FIFO
//  RdValid      out  1   FIFO non-empty
//  RdReady      in   1   pop head when RdValid&&RdReady
//  Count        out  log2(DEPTH)+1  current occupancy
//  Overflow     out  1   sticky: a record was dropped
//  DropCount    out  8   dropped records, saturates at 255
//  Busy         out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset (CtrlRst_n==0 at posedge): FSM=IDLE; FIFO empty; PrevState=0; all outputs 0.
//    Reset wins over every other input, including mid-capture.
//  FSM states: IDLE, ARMED, CAPTURE, DONE.
//    IDLE/DONE + Arm -> CAPTURE, or ARMED when macro on.
//    CAPTURE + full + STOP_ON_FULL -> DONE.
//    Disarm in any state -> IDLE. Disarm beats Arm in the same cycle.
//    Arm while in ARMED/CAPTURE: flags cleared, state unchanged.
//  PrevState <= CurrentState every cycle, in every state.
//  Capture condition in CAPTURE: CAPTURE_ALL || CurrentState != PrevState || first CAPTURE cycle.
//    The first CAPTURE cycle always records.
//  Push: record = inputs sampled at that posedge. RdValid/RdData update on the next cycle.
//    No bypass path: FIFO latency is 1 cycle.
//  Pop: RdValid&&RdReady; RdData shows the next entry on the following cycle.
//  Push+pop same cycle: both execute, including when the FIFO is full.
//    Count stays constant; no drop when full.
//  Push with FIFO full and no pop: record discarded; Overflow<=1; DropCount+1, saturating.
//    With STOP_ON_FULL, DONE is entered on the push that fills the FIFO, so no drops occur.
//  Pointers are log2(DEPTH) bits and wrap naturally. Count = wr - rd, one extra bit.
//  Reads remain legal in every state, including IDLE.
// CONFIGURATION
//  CPU_TRACE_PC_TRIGGER_EN defined: Arm -> ARMED.
//    ARMED -> CAPTURE on the first cycle with PCIn==TrigPC; that cycle is recorded.
//  Undefined: Arm -> CAPTURE directly. ARMED is unreachable; encoding reserved. TrigPC unused.
// STRUCTURE
//  cpu_trace_pkg contents:
//    TRACE_W=85 and field offsets
//    state localparams IDLE=0, ARMED=1, CAPTURE=2, DONE=3
//    DROP_MAX=255
//  Sub-module trace_fifo (DEPTH, WIDTH): sync FIFO, push/pop/full/empty/count, simultaneous push+pop on full.
//  Top level holds the FSM, change detector, and drop counter.
// TESTING
//  Reset: assert CtrlRst_n=0 mid-CAPTURE with 3 entries -> next cycle Count=0, RdValid=0, Busy=0.
//  Change filter: Arm; CurrentState 1,1,2,2,3 with CAPTURE_ALL=0 -> 3 records, states 1,2,3; PC fields match.
//  Overflow: DEPTH=4, CAPTURE_ALL=1, RdReady=0, 6 capture cycles.
//    -> Count=4, Overflow=1, DropCount=2; drained records are the first 4.
//  Full push+pop: full FIFO, RdReady=1, capture each cycle.
//    -> Count stays 4, no drops, records in order.
//  STOP_ON_FULL=1, DEPTH=4, CAPTURE_ALL=1 -> DONE after 4th push; Busy=1; DropCount=0.
//    Arm -> CAPTURE, flags clear.
//  Macro on: TrigPC=16'h0040; PC 3C,3E,40,42 -> first record PC=0x0040.
//    Arm and Disarm in the same cycle -> IDLE.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared definitions for the CPU trace buffer.
//   TRACE_W  : width of one trace record
//   *_LSB    : bit offsets of the record fields
//              {State[84:80], PC, MSP, RSP, ValA, ValB}
//   DROP_MAX : saturation value of the dropped-record counter
//   traceState_e : capture FSM states (ARMED only used with CPU_TRACE_PC_TRIGGER_EN)
package cpu_trace_pkg;

  localparam int TRACE_W  = 85;
  localparam int ST_LSB   = 80;
  localparam int PC_LSB   = 64;
  localparam int MSP_LSB  = 48;
  localparam int RSP_LSB  = 32;
  localparam int VALA_LSB = 16;
  localparam int VALB_LSB = 0;

  localparam logic [7:0] DROP_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } traceState_e;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO used as the trace record store.
// Ports:
//   CLK, CtrlRst_n : clock, synchronous active-low reset
//   Push/PushData  : write request and data (ignored when full unless popping)
//   Pop            : read request (ignored when empty)
//   PopData        : head entry, zero when empty
//   Full, Empty    : occupancy flags
//   Count          : occupancy, one bit wider than the pointers
// Push and pop in the same cycle both take effect, even when full.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 85
) (
  input  logic                     CLK,
  input  logic                     CtrlRst_n,
  input  logic                     Push,
  input  logic [WIDTH-1:0]         PushData,
  input  logic                     Pop,
  output logic [WIDTH-1:0]         PopData,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wrPtr_r;
  logic [AW-1:0]    rdPtr_r;
  logic [CW-1:0]    count_r;
  logic             pushOk_s;
  logic             popOk_s;

  assign Empty    = (count_r == {CW{1'b0}});
  assign Full     = (count_r == CW'(DEPTH));
  assign popOk_s  = Pop && !Empty;
  assign pushOk_s = Push && (!Full || popOk_s);
  assign Count    = count_r;
  assign PopData  = Empty ? {WIDTH{1'b0}} : mem_r[rdPtr_r];

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK) begin
    if (!CtrlRst_n) begin
      wrPtr_r <= {AW{1'b0}};
      rdPtr_r <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (pushOk_s) begin
        wrPtr_r <= wrPtr_r + AW'(1'b1);
      end else begin
        wrPtr_r <= wrPtr_r;
      end
      if (popOk_s) begin
        rdPtr_r <= rdPtr_r + AW'(1'b1);
      end else begin
        rdPtr_r <= rdPtr_r;
      end
      case ({pushOk_s, popOk_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset because Count gates visibility.
  always_ff @(posedge CLK) begin
    if (pushOk_s) begin
      mem_r[wrPtr_r] <= PushData;
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: passive observer of the CPU debug outputs. Records one
// trace entry per control-FSM state change (or every cycle) into a FIFO that
// drains through a valid/ready read port.
// Ports:
//   CLK, CtrlRst_n           : clock, synchronous active-low reset
//   CurrentState, PCIn, MSPIn, RSPIn, ValAIn, ValBIn : observed CPU signals
//   Arm / Disarm             : start capture (clears drop flags) / abort to IDLE
//   TrigPC                   : PC trigger, used only with CPU_TRACE_PC_TRIGGER_EN
//   RdData, RdValid, RdReady : FIFO head read port
//   Count                    : FIFO occupancy
//   Overflow, DropCount      : sticky drop flag, saturating drop counter
//   Busy                     : capture FSM not idle
// Build option: define CPU_TRACE_PC_TRIGGER_EN so Arm waits in ARMED until
// PCIn == TrigPC before capturing.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter bit CAPTURE_ALL  = 1'b0,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic                   CLK,
  input  logic                   CtrlRst_n,
  input  logic [4:0]             CurrentState,
  input  logic [15:0]            PCIn,
  input  logic [15:0]            MSPIn,
  input  logic [15:0]            RSPIn,
  input  logic [15:0]            ValAIn,
  input  logic [15:0]            ValBIn,
  input  logic                   Arm,
  input  logic                   Disarm,
  input  logic [15:0]            TrigPC,
  output logic [TRACE_W-1:0]     RdData,
  output logic                   RdValid,
  input  logic                   RdReady,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow,
  output logic [7:0]             DropCount,
  output logic                   Busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  traceState_e        state_r;
  traceState_e        nextState_s;
  logic [4:0]         prevState_r;
  logic               firstCap_r;
  logic               busy_r;
  logic               overflow_r;
  logic [7:0]         dropCount_r;
  logic [TRACE_W-1:0] record_s;
  logic               capCond_s;
  logic               trigHit_s;
  logic               armOk_s;
  logic               popOk_s;
  logic               pushOk_s;
  logic               drop_s;
  logic               full_s;
  logic               empty_s;
  logic [CNT_W-1:0]   cntNext_s;

`ifdef CPU_TRACE_PC_TRIGGER_EN
  localparam traceState_e ARM_TARGET = ARMED;
  assign trigHit_s = (state_r == ARMED) && (PCIn == TrigPC);
`else
  localparam traceState_e ARM_TARGET = CAPTURE;
  logic unusedTrig_s;
  assign unusedTrig_s = ^TrigPC;
  assign trigHit_s    = 1'b0;
`endif

  always_comb begin
    record_s                          = {TRACE_W{1'b0}};
    record_s[ST_LSB   +: 5]           = CurrentState;
    record_s[PC_LSB   +: 16]          = PCIn;
    record_s[MSP_LSB  +: 16]          = MSPIn;
    record_s[RSP_LSB  +: 16]          = RSPIn;
    record_s[VALA_LSB +: 16]          = ValAIn;
    record_s[VALB_LSB +: 16]          = ValBIn;
  end

  // Arm is ignored when Disarm is asserted in the same cycle.
  assign armOk_s  = Arm && !Disarm;
  assign popOk_s  = !empty_s && RdReady;
  assign pushOk_s = capCond_s && (!full_s || popOk_s);
  assign drop_s   = capCond_s && !pushOk_s;
  assign RdValid  = !empty_s;

  // Record decision: the trigger cycle in ARMED, or the change filter in CAPTURE.
  always_comb begin
    if (state_r == CAPTURE) begin
      capCond_s = CAPTURE_ALL || (CurrentState != prevState_r) || firstCap_r;
    end else begin
      capCond_s = trigHit_s;
    end
  end

  // Occupancy after this cycle's push/pop, used to stop on the filling push.
  always_comb begin
    case ({pushOk_s, popOk_s})
      2'b10:   cntNext_s = Count + CNT_W'(1'b1);
      2'b01:   cntNext_s = Count - CNT_W'(1'b1);
      default: cntNext_s = Count;
    endcase
  end

  // Capture FSM next state; Disarm overrides everything.
  always_comb begin
    nextState_s = state_r;
    if (Disarm) begin
      nextState_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (Arm) begin
            nextState_s = ARM_TARGET;
          end else begin
            nextState_s = state_r;
          end
        end
        ARMED: begin
          if (trigHit_s) begin
            nextState_s = CAPTURE;
          end else if (ARM_TARGET == ARMED) begin
            nextState_s = ARMED;
          end else begin
            nextState_s = IDLE;
          end
        end
        CAPTURE: begin
          if (STOP_ON_FULL && (cntNext_s == CNT_W'(DEPTH))) begin
            nextState_s = DONE;
          end else begin
            nextState_s = CAPTURE;
          end
        end
        default: nextState_s = IDLE;
      endcase
    end
  end

  // FSM state, previous-state tracker and first-capture-cycle flag.
  always_ff @(posedge CLK) begin
    if (!CtrlRst_n) begin
      state_r     <= IDLE;
      prevState_r <= 5'd0;
      firstCap_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= nextState_s;
      prevState_r <= CurrentState;
      firstCap_r  <= ((state_r == IDLE) || (state_r == DONE)) && (nextState_s == CAPTURE);
      busy_r      <= (nextState_s != IDLE);
    end
  end

  // Drop flags; a fresh Arm clears them even if a drop happens that cycle.
  always_ff @(posedge CLK) begin
    if (!CtrlRst_n) begin
      overflow_r  <= 1'b0;
      dropCount_r <= 8'd0;
    end else if (armOk_s) begin
      overflow_r  <= 1'b0;
      dropCount_r <= 8'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (dropCount_r != DROP_MAX) begin
        dropCount_r <= dropCount_r + 8'd1;
      end else begin
        dropCount_r <= dropCount_r;
      end
    end else begin
      overflow_r  <= overflow_r;
      dropCount_r <= dropCount_r;
    end
  end

  assign Busy      = busy_r;
  assign Overflow  = overflow_r;
  assign DropCount = dropCount_r;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_W)
  ) u_fifo (
    .CLK       (CLK),
    .CtrlRst_n (CtrlRst_n),
    .Push      (pushOk_s),
    .PushData  (record_s),
    .Pop       (popOk_s),
    .PopData   (RdData),
    .Full      (full_s),
    .Empty     (empty_s),
    .Count     (Count)
  );

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: three DEPTH=4 instances share one stimulus
//   u[0]: change filter, u[1]: capture all, u[2]: capture all + stop on full.
module tb_cpu_trace_buffer;

  logic        CLK = 1'b0;
  logic        CtrlRst_n;
  logic [4:0]  CurrentState;
  logic [15:0] PCIn, MSPIn, RSPIn, ValAIn, ValBIn, TrigPC;
  logic        Arm, Disarm, RdReady;

  logic [84:0] rdData  [3];
  logic        rdValid [3];
  logic [2:0]  cnt     [3];
  logic        ovf     [3];
  logic [7:0]  dropCnt [3];
  logic        busy    [3];

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cpu_trace_buffer #(
      .DEPTH        (4),
      .CAPTURE_ALL  (g != 0),
      .STOP_ON_FULL (g == 2)
    ) u_dut (
      .CLK          (CLK),
      .CtrlRst_n    (CtrlRst_n),
      .CurrentState (CurrentState),
      .PCIn         (PCIn),
      .MSPIn        (MSPIn),
      .RSPIn        (RSPIn),
      .ValAIn       (ValAIn),
      .ValBIn       (ValBIn),
      .Arm          (Arm),
      .Disarm       (Disarm),
      .TrigPC       (TrigPC),
      .RdData       (rdData[g]),
      .RdValid      (rdValid[g]),
      .RdReady      (RdReady),
      .Count        (cnt[g]),
      .Overflow     (ovf[g]),
      .DropCount    (dropCnt[g]),
      .Busy         (busy[g])
    );
  end

  // Reference model: a queue of records per instance plus mode flags.
  logic [84:0] mq [3][$];
  bit          mCap [3], mDone [3], mWait [3], mFirst [3], mOvf [3];
  int          mDrop [3];
  logic [4:0]  mPrev;

  task automatic model_step();
    logic [84:0] rec;
    bit pop, want, trig, dropped, idleDone;
    rec = {CurrentState, PCIn, MSPIn, RSPIn, ValAIn, ValBIn};
    for (int i = 0; i < 3; i++) begin
      if (!CtrlRst_n) begin
        mq[i].delete();
        mCap[i] = 0; mDone[i] = 0; mWait[i] = 0; mFirst[i] = 0;
        mOvf[i] = 0; mDrop[i] = 0;
      end else begin
        pop  = (mq[i].size() != 0) && RdReady;
        trig = 0;
`ifdef CPU_TRACE_PC_TRIGGER_EN
        trig = mWait[i] && (PCIn == TrigPC);
`endif
        want = trig || (mCap[i] && ((i != 0) || (CurrentState != mPrev) || mFirst[i]));
        if (pop) void'(mq[i].pop_front());
        dropped = 0;
        if (want) begin
          if (mq[i].size() < 4) mq[i].push_back(rec);
          else dropped = 1;
        end
        if (Arm && !Disarm) begin
          mOvf[i] = 0; mDrop[i] = 0;
        end else if (dropped) begin
          mOvf[i] = 1;
          if (mDrop[i] < 255) mDrop[i]++;
        end
        idleDone  = !mCap[i] && !mWait[i];
        mFirst[i] = 0;
        if (Disarm) begin
          mCap[i] = 0; mDone[i] = 0; mWait[i] = 0;
        end else if (idleDone && Arm) begin
          mDone[i] = 0;
`ifdef CPU_TRACE_PC_TRIGGER_EN
          mWait[i] = 1;
`else
          mCap[i] = 1; mFirst[i] = 1;
`endif
        end else if (trig) begin
          mWait[i] = 0; mCap[i] = 1;
        end else if (mCap[i] && (i == 2) && (mq[i].size() == 4)) begin
          mCap[i] = 0; mDone[i] = 1;
        end
      end
    end
    mPrev = CtrlRst_n ? CurrentState : 5'd0;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: update the model with the pre-edge inputs, then sample #1 after.
  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    CtrlRst_n = 1'b0; Arm = 1'b0; Disarm = 1'b0; RdReady = 1'b0;
    step();
    CtrlRst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [4:0]  cs;
    logic [15:0] pc;
    logic        rec;
    logic [2:0]  cnt;
  } vec_t;
  vec_t tbl [5];

  logic [98:0] actV, expV;

  initial begin
    tbl[0] = '{cs: 5'd1, pc: 16'h0100, rec: 1'b1, cnt: 3'd1};
    tbl[1] = '{cs: 5'd1, pc: 16'h0102, rec: 1'b0, cnt: 3'd1};
    tbl[2] = '{cs: 5'd2, pc: 16'h0104, rec: 1'b1, cnt: 3'd2};
    tbl[3] = '{cs: 5'd2, pc: 16'h0106, rec: 1'b0, cnt: 3'd2};
    tbl[4] = '{cs: 5'd3, pc: 16'h0108, rec: 1'b1, cnt: 3'd3};

    CtrlRst_n = 1'b0; CurrentState = 5'd0; PCIn = 16'h0; MSPIn = 16'h1111;
    RSPIn = 16'h2222; ValAIn = 16'h3333; ValBIn = 16'h4444; TrigPC = 16'h0040;
    Arm = 1'b0; Disarm = 1'b0; RdReady = 1'b0;
    step(); step();
    for (int i = 0; i < 3; i++)
      chk("reset_state", 128'({rdData[i], rdValid[i], cnt[i], ovf[i], dropCnt[i], busy[i]}), 128'd0);
    CtrlRst_n = 1'b1;

    // Reset in the middle of a capture with 3 entries.
    Arm = 1'b1; step(); Arm = 1'b0;
    for (int k = 0; k < 3; k++) begin PCIn = 16'h0010 + 16'(k); step(); end
    chk("midcap_count", 128'(cnt[1]), 128'd3);
    chk("midcap_busy", 128'(busy[1]), 128'd1);
    CtrlRst_n = 1'b0; step();
    chk("midcap_rst_count", 128'(cnt[1]), 128'd0);
    chk("midcap_rst_valid", 128'(rdValid[1]), 128'd0);
    chk("midcap_rst_busy", 128'(busy[1]), 128'd0);
    CtrlRst_n = 1'b1;

    // Change filter on u[0], table driven.
    CurrentState = 5'd0; Arm = 1'b1; step(); Arm = 1'b0;
    for (int r = 0; r < 5; r++) begin
      CurrentState = tbl[r].cs; PCIn = tbl[r].pc; step();
      chk("filter_count", 128'(cnt[0]), 128'(tbl[r].cnt));
    end
    RdReady = 1'b1;
    for (int r = 0; r < 5; r++) begin
      if (tbl[r].rec) begin
        chk("filter_state", 128'(rdData[0][84:80]), 128'(tbl[r].cs));
        chk("filter_pc", 128'(rdData[0][79:64]), 128'(tbl[r].pc));
        step();
      end
    end
    chk("filter_drained", 128'(rdValid[0]), 128'd0);

    // Overflow on u[1]: 6 captures into a 4-deep FIFO with no reads.
    do_reset();
    Arm = 1'b1; step(); Arm = 1'b0;
    for (int k = 0; k < 6; k++) begin PCIn = 16'h0200 + 16'(k); step(); end
    chk("ovf_count", 128'(cnt[1]), 128'd4);
    chk("ovf_flag", 128'(ovf[1]), 128'd1);
    chk("ovf_drops", 128'(dropCnt[1]), 128'd2);

    // Full FIFO with push+pop every cycle: occupancy holds, order preserved.
    RdReady = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("fullpp_head", 128'(rdData[1][79:64]),
          128'((j < 4) ? (16'h0200 + 16'(j)) : (16'h0300 + 16'(j - 4))));
      PCIn = 16'h0300 + 16'(j); step();
      chk("fullpp_count", 128'(cnt[1]), 128'd4);
      chk("fullpp_drops", 128'(dropCnt[1]), 128'd2);
    end

    // Stop on full (u[2]).
    do_reset();
    Arm = 1'b1; step(); Arm = 1'b0;
    for (int k = 0; k < 4; k++) begin PCIn = 16'h0400 + 16'(k); step(); end
    chk("stop_busy", 128'(busy[2]), 128'd1);
    chk("stop_count", 128'(cnt[2]), 128'd4);
    chk("stop_drops", 128'(dropCnt[2]), 128'd0);
    step();
    chk("stop_hold_count", 128'(cnt[2]), 128'd4);
    chk("stop_hold_ovf", 128'(ovf[2]), 128'd0);
    Arm = 1'b1; RdReady = 1'b1; step(); Arm = 1'b0;
    chk("stop_rearm_pop", 128'(cnt[2]), 128'd3);
    step();
    chk("stop_rearm_capture", 128'(cnt[2]), 128'd3);
    RdReady = 1'b0;

    // Disarm beats Arm.
    Arm = 1'b1; Disarm = 1'b1; step(); Arm = 1'b0; Disarm = 1'b0;
    chk("disarm_wins_0", 128'(busy[0]), 128'd0);
    chk("disarm_wins_2", 128'(busy[2]), 128'd0);

    // Drop counter saturation, then Arm clears the flags.
    do_reset();
    Arm = 1'b1; step(); Arm = 1'b0;
    repeat (262) step();
    chk("sat_drops", 128'(dropCnt[1]), 128'd255);
    chk("sat_ovf", 128'(ovf[1]), 128'd1);
    Arm = 1'b1; step(); Arm = 1'b0;
    chk("arm_clr_drops", 128'(dropCnt[1]), 128'd0);
    chk("arm_clr_ovf", 128'(ovf[1]), 128'd0);

`ifdef CPU_TRACE_PC_TRIGGER_EN
    do_reset();
    TrigPC = 16'h0040;
    Arm = 1'b1; step(); Arm = 1'b0;
    PCIn = 16'h003C; step();
    PCIn = 16'h003E; step();
    chk("trig_wait_count", 128'(cnt[1]), 128'd0);
    PCIn = 16'h0040; step();
    PCIn = 16'h0042; step();
    chk("trig_first_pc", 128'(rdData[1][79:64]), 128'h0040);
`endif

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      CtrlRst_n = ($urandom_range(0, 63) != 0);
      Arm       = ($urandom_range(0, 15) == 0);
      Disarm    = ($urandom_range(0, 31) == 0);
      RdReady   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) CurrentState = 5'($urandom_range(0, 3));
      PCIn   = ($urandom_range(0, 3) == 0) ? TrigPC : 16'($urandom);
      MSPIn  = 16'($urandom);
      RSPIn  = 16'($urandom);
      ValAIn = 16'($urandom);
      ValBIn = 16'($urandom);
      step();
      for (int i = 0; i < 3; i++) begin
        actV = {rdData[i], rdValid[i], cnt[i], ovf[i], dropCnt[i], busy[i]};
        expV = {(mq[i].size() != 0) ? mq[i][0] : 85'd0, mq[i].size() != 0,
                3'(mq[i].size()), mOvf[i], 8'(mDrop[i]), mCap[i] || mDone[i] || mWait[i]};
        chk("random_outputs", 128'(actV), 128'(expV));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
